// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host frame receiver producing a 3-byte scan-code history.
// Latency: o_valid/o_frame_err are registered one cycle after the filtered falling edge; no backpressure.
`timescale 1ns/1ps
module ps2_scan_receiver #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ps2_clk,
    input  logic        i_ps2_data,
    output logic [23:0] o_Data,
    output logic        o_valid,
    output logic        o_frame_err,
    output logic        o_busy
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_s;
    logic                   data_s;

    logic                   filt_q;
    logic                   filt_d;
    logic                   filt_prev_q;
    logic [7:0]             filt_cnt_q;
    logic [7:0]             filt_cnt_d;
    logic                   fall;

    state_t                 state_q;
    state_t                 state_d;
    logic [2:0]             bit_cnt_q;
    logic [2:0]             bit_cnt_d;
    logic [7:0]             shift_q;
    logic [7:0]             shift_d;
    logic                   parity_q;
    logic                   parity_d;
    logic [23:0]            data_q;
    logic [23:0]            data_d;
    logic                   valid_q;
    logic                   valid_d;
    logic                   err_q;
    logic                   err_d;
    logic [TMO_W-1:0]       tmo_q;
    logic [TMO_W-1:0]       tmo_d;

    // Pins idle high, so the synchronizers reset to 1 to avoid a spurious fall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], i_ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], i_ps2_data};
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == 8'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    assign fall = filt_prev_q & ~filt_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        tmo_d     = (state_q == IDLE) ? '0 : tmo_q + TMO_W'(1);

        case (state_q)
            IDLE: begin
                if (fall) begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_d = data_s;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (data_s && (^{shift_q, parity_q})) begin
                        data_d  = {data_q[15:0], shift_q};
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A fall in the same cycle as expiry is a live bit, so it takes priority.
        if (fall) begin
            tmo_d = '0;
        end else if (state_q != IDLE && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    assign o_Data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = err_q;
    assign o_busy      = (state_q != IDLE);

endmodule
